turn_controller: RTL and testbench

// Sequences a two-player turn-based game: owns whose turn it is, drives the per-turn

---
 rtl/turn_controller.sv | 173 +++++++++++++++++
 tb/tb_turn_controller.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/turn_controller.sv
// -----------------------------------------------------------------------------
// turn_controller
//
// Sequences a two-player turn-based game. It owns whose turn it is and runs
// the per-turn countdown timer. It forwards the active player's move to the
// board as a request/ack handshake, waits for the win/draw checker, and then
// passes the turn to the other player.
//
// Ports
//   clk, rst        system clock; synchronous active-high reset
//   start           pulse: begin a new game (only honoured when idle or over)
//   p1_move_vld/col player 1 move strobe and column
//   p2_move_vld/col player 2 move strobe and column
//   timer_timeout   one-cycle pulse from the turn timer
//   place_req/col/player  pending board request (held until place_ack)
//   place_ack/ok    board response: ok=1 placed, ok=0 column full
//   chk_valid/win/draw    checker result for the last placed piece
//   timer_enable    turn timer runs
//   timer_restart   one-cycle pulse: timer back to zero
//   cur_player      0 = player 1, 1 = player 2
//   game_over       game has finished
//   winner          00 none/draw, 01 P1, 10 P2, 11 aborted by timeouts
// -----------------------------------------------------------------------------
module turn_controller #(
    parameter int COLS      = 7,
    parameter int COL_W     = 3,
    parameter int MAX_SKIPS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             p1_move_vld,
    input  logic [COL_W-1:0] p1_move_col,
    input  logic             p2_move_vld,
    input  logic [COL_W-1:0] p2_move_col,
    input  logic             timer_timeout,
    output logic             place_req,
    output logic [COL_W-1:0] place_col,
    output logic             place_player,
    input  logic             place_ack,
    input  logic             place_ok,
    input  logic             chk_valid,
    input  logic             chk_win,
    input  logic             chk_draw,
    output logic             timer_enable,
    output logic             timer_restart,
    output logic             cur_player,
    output logic             game_over,
    output logic [1:0]       winner
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TURN,
        S_PLACE,
        S_CHECK,
        S_OVER
    } state_t;

    localparam int SKIP_W = $clog2(MAX_SKIPS + 1);
    localparam logic [SKIP_W-1:0] LAST_SKIP = SKIP_W'(MAX_SKIPS - 1);

    state_t            state;
    logic [SKIP_W-1:0] skips;

    // Move of whichever player currently holds the turn; the other player's
    // strobe never reaches the sequencing logic.
    logic             mover_vld;
    logic [COL_W-1:0] mover_col;
    logic             move_ok;

    // NOTE: every signal assigned in always_comb gets a value on every path,
    // so no latch is inferred.
    always_comb begin
        mover_vld = cur_player ? p2_move_vld : p1_move_vld;
        mover_col = cur_player ? p2_move_col : p1_move_col;
        move_ok   = mover_vld && (int'(mover_col) < COLS);
    end

    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            skips         <= '0;
            place_req     <= 1'b0;
            place_col     <= '0;
            place_player  <= 1'b0;
            timer_enable  <= 1'b0;
            timer_restart <= 1'b0;
            cur_player    <= 1'b0;
            game_over     <= 1'b0;
            winner        <= 2'b00;
        end else begin
            // timer_restart is a single-cycle pulse unless re-armed below.
            timer_restart <= 1'b0;

            case (state)
                S_IDLE, S_OVER: begin
                    if (start) begin
                        state         <= S_TURN;
                        cur_player    <= 1'b0;
                        timer_restart <= 1'b1;
                        timer_enable  <= 1'b1;
                        game_over     <= 1'b0;
                        winner        <= 2'b00;
                        skips         <= '0;
                    end
                end

                S_TURN: begin
                    // A legal move beats a same-cycle timeout; the timeout is
                    // dropped and does not count as a skip.
                    if (move_ok) begin
                        state        <= S_PLACE;
                        place_req    <= 1'b1;
                        place_col    <= mover_col;
                        place_player <= cur_player;
                        timer_enable <= 1'b0;  // frozen, not restarted
                    end else if (timer_timeout) begin
                        if (skips == LAST_SKIP) begin
                            state        <= S_OVER;
                            game_over    <= 1'b1;
                            winner       <= 2'b11;
                            timer_enable <= 1'b0;
                        end else begin
                            skips         <= skips + 1'b1;
                            cur_player    <= ~cur_player;
                            timer_restart <= 1'b1;
                        end
                    end
                end

                S_PLACE: begin
                    if (place_ack) begin
                        place_req <= 1'b0;
                        if (place_ok) begin
                            state <= S_CHECK;
                            skips <= '0;
                        end else begin
                            // Column full: same player retries, timer resumes
                            // from where it was frozen.
                            state        <= S_TURN;
                            timer_enable <= 1'b1;
                        end
                    end
                end

                S_CHECK: begin
                    if (chk_valid) begin
                        if (chk_win) begin
                            state     <= S_OVER;
                            game_over <= 1'b1;
                            winner    <= cur_player ? 2'b10 : 2'b01;
                        end else if (chk_draw) begin
                            state     <= S_OVER;
                            game_over <= 1'b1;
                            winner    <= 2'b00;
                        end else begin
                            state         <= S_TURN;
                            cur_player    <= ~cur_player;
                            timer_restart <= 1'b1;
                            timer_enable  <= 1'b1;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_turn_controller.sv
// -----------------------------------------------------------------------------
// tb_turn_controller
//
// Self-checking bench for turn_controller: a table of per-cycle input/expected
// output records, a hand-written stall sequence on the place handshake, and a
// randomized run compared against a behavioural game model.
// -----------------------------------------------------------------------------
module tb_turn_controller;

    localparam int COLS  = 7;
    localparam int COL_W = 3;

    typedef struct packed {
        logic             rst;
        logic             start;
        logic             p1v;
        logic [COL_W-1:0] p1c;
        logic             p2v;
        logic [COL_W-1:0] p2c;
        logic             to;
        logic             ack;
        logic             ok;
        logic             cv;
        logic             win;
        logic             draw;
    } in_t;

    typedef struct packed {
        logic             req;
        logic [COL_W-1:0] col;
        logic             pl;
        logic             ten;
        logic             trs;
        logic             cur;
        logic             go;
        logic [1:0]       win;
    } out_t;

    typedef struct {
        string name;
        in_t   i;
        out_t  o;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst, start, p1_move_vld, p2_move_vld, timer_timeout;
    logic [COL_W-1:0] p1_move_col, p2_move_col, place_col;
    logic             place_req, place_player, place_ack, place_ok;
    logic             chk_valid, chk_win, chk_draw;
    logic             timer_enable, timer_restart, cur_player, game_over;
    logic [1:0]       winner;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    turn_controller #(.COLS(COLS), .COL_W(COL_W), .MAX_SKIPS(4)) dut (
        .clk(clk), .rst(rst), .start(start),
        .p1_move_vld(p1_move_vld), .p1_move_col(p1_move_col),
        .p2_move_vld(p2_move_vld), .p2_move_col(p2_move_col),
        .timer_timeout(timer_timeout),
        .place_req(place_req), .place_col(place_col), .place_player(place_player),
        .place_ack(place_ack), .place_ok(place_ok),
        .chk_valid(chk_valid), .chk_win(chk_win), .chk_draw(chk_draw),
        .timer_enable(timer_enable), .timer_restart(timer_restart),
        .cur_player(cur_player), .game_over(game_over), .winner(winner)
    );

    // ---------------- stimulus helpers ----------------
    function automatic in_t f_none();
        in_t v;
        v = '0;
        return v;
    endfunction
    function automatic in_t f_rst();
        in_t v = '0; v.rst = 1'b1; return v;
    endfunction
    function automatic in_t f_start();
        in_t v = '0; v.start = 1'b1; return v;
    endfunction
    function automatic in_t f_to();
        in_t v = '0; v.to = 1'b1; return v;
    endfunction
    function automatic in_t f_p1(input int c);
        in_t v = '0; v.p1v = 1'b1; v.p1c = COL_W'(c); return v;
    endfunction
    function automatic in_t f_p2(input int c);
        in_t v = '0; v.p2v = 1'b1; v.p2c = COL_W'(c); return v;
    endfunction
    function automatic in_t f_ack(input logic ok);
        in_t v = '0; v.ack = 1'b1; v.ok = ok; return v;
    endfunction
    function automatic in_t f_chk(input logic w, input logic d);
        in_t v = '0; v.cv = 1'b1; v.win = w; v.draw = d; return v;
    endfunction
    function automatic in_t f_or(input in_t a, input in_t b);
        return in_t'(a | b);
    endfunction
    function automatic out_t o(input logic req, input int col, input logic pl,
                               input logic ten, input logic trs, input logic cur,
                               input logic go, input int win);
        out_t r;
        r.req = req; r.col = COL_W'(col); r.pl = pl; r.ten = ten;
        r.trs = trs; r.cur = cur; r.go = go; r.win = 2'(win);
        return r;
    endfunction

    function automatic out_t get_out();
        out_t r;
        r.req = place_req; r.col = place_col; r.pl = place_player;
        r.ten = timer_enable; r.trs = timer_restart; r.cur = cur_player;
        r.go = game_over; r.win = winner;
        return r;
    endfunction

    task automatic drive(input in_t v);
        rst = v.rst; start = v.start;
        p1_move_vld = v.p1v; p1_move_col = v.p1c;
        p2_move_vld = v.p2v; p2_move_col = v.p2c;
        timer_timeout = v.to; place_ack = v.ack; place_ok = v.ok;
        chk_valid = v.cv; chk_win = v.win; chk_draw = v.draw;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural game model ----------------
    // Tracks the game as "is a game running", "is a piece in flight to the
    // board", "is a result awaited", rather than as an explicit state machine.
    bit       m_playing, m_over, m_judging, m_cur, m_restart, m_last_pl;
    int       m_skips, m_last_col;
    bit [1:0] m_winner;
    int       m_inflight[$];

    function automatic void m_end(input bit [1:0] w);
        m_playing = 1'b0;
        m_over    = 1'b1;
        m_winner  = w;
    endfunction

    function automatic void model_step(input in_t v);
        bit mv;
        int mc;
        m_restart = 1'b0;
        if (v.rst) begin
            m_playing = 0; m_over = 0; m_judging = 0; m_cur = 0; m_last_pl = 0;
            m_skips = 0; m_last_col = 0; m_winner = 0;
            m_inflight.delete();
        end else if (!m_playing) begin
            if (v.start) begin
                m_playing = 1; m_over = 0; m_cur = 0; m_skips = 0;
                m_winner = 0; m_restart = 1;
            end
        end else if (m_inflight.size() != 0) begin
            if (v.ack) begin
                void'(m_inflight.pop_front());
                if (v.ok) begin
                    m_judging = 1;
                    m_skips   = 0;
                end
            end
        end else if (m_judging) begin
            if (v.cv) begin
                m_judging = 0;
                if (v.win)       m_end(m_cur ? 2'd2 : 2'd1);
                else if (v.draw) m_end(2'd0);
                else begin
                    m_cur = !m_cur;
                    m_restart = 1;
                end
            end
        end else begin
            mv = m_cur ? v.p2v : v.p1v;
            mc = m_cur ? int'(v.p2c) : int'(v.p1c);
            if (mv && mc < COLS) begin
                m_inflight.push_back(mc);
                m_last_col = mc;
                m_last_pl  = m_cur;
            end else if (v.to) begin
                m_skips++;
                if (m_skips == 4) m_end(2'd3);
                else begin
                    m_cur = !m_cur;
                    m_restart = 1;
                end
            end
        end
    endfunction

    function automatic out_t model_out();
        out_t r;
        r.req = (m_inflight.size() != 0);
        r.col = COL_W'(m_last_col);
        r.pl  = m_last_pl;
        r.ten = m_playing && (m_inflight.size() == 0) && !m_judging;
        r.trs = m_restart;
        r.cur = m_cur;
        r.go  = m_over;
        r.win = m_winner;
        return r;
    endfunction

    // One clock: apply inputs, let the edge pass, sample 1 time unit later.
    task automatic run_cycle(input in_t v, output out_t act);
        drive(v);
        @(posedge clk);
        #1;
        model_step(v);
        act = get_out();
    endtask

    // ---------------- directed table ----------------
    vec_t tbl[$];

    task automatic add(input string n, input in_t i, input out_t ex);
        vec_t e;
        e.name = n; e.i = i; e.o = ex;
        tbl.push_back(e);
    endtask

    initial begin
        out_t act, exp_o;
        in_t  v;

        drive(f_rst());

        // reset, first move, ack, no result -> P2 turn with restart
        add("reset",        f_rst(),                o(0,0,0,0,0,0,0,0));
        add("start",        f_start(),              o(0,0,0,1,1,0,0,0));
        add("p1_move3",     f_p1(3),                o(1,3,0,0,0,0,0,0));
        add("hold_req",     f_none(),               o(1,3,0,0,0,0,0,0));
        add("ack_ok",       f_ack(1),               o(0,3,0,0,0,0,0,0));
        add("chk_none",     f_chk(0,0),             o(0,3,0,1,1,1,0,0));
        add("restart_drop", f_none(),               o(0,3,0,1,0,1,0,0));
        // wrong player and out-of-range column ignored
        add("wrong_player", f_or(f_p1(2), f_p2(7)), o(0,3,0,1,0,1,0,0));
        add("col_7_ignored",f_p2(7),                o(0,3,0,1,0,1,0,0));
        // move and timeout together: move wins, no skip
        add("move_vs_to",   f_or(f_p2(0), f_to()),  o(1,0,1,0,0,1,0,0));
        add("ack_full",     f_ack(0),               o(0,0,1,1,0,1,0,0));
        // four timeouts abort the game
        add("skip1",        f_to(),                 o(0,0,1,1,1,0,0,0));
        add("skip2",        f_to(),                 o(0,0,1,1,1,1,0,0));
        add("skip3",        f_to(),                 o(0,0,1,1,1,0,0,0));
        add("skip4_abort",  f_to(),                 o(0,0,1,0,0,0,1,3));
        add("over_hold",    f_none(),               o(0,0,1,0,0,0,1,3));
        add("over_move",    f_p1(1),                o(0,0,1,0,0,0,1,3));
        add("over_to",      f_to(),                 o(0,0,1,0,0,0,1,3));
        // P2 wins with win and draw together
        add("restart_game", f_start(),              o(0,0,1,1,1,0,0,0));
        add("p1_col6",      f_p1(6),                o(1,6,0,0,0,0,0,0));
        add("ack_ok2",      f_ack(1),               o(0,6,0,0,0,0,0,0));
        add("chk_none2",    f_chk(0,0),             o(0,6,0,1,1,1,0,0));
        add("p2_move1",     f_p2(1),                o(1,1,1,0,0,1,0,0));
        add("ack_ok_to",    f_or(f_ack(1), f_to()), o(0,1,1,0,0,1,0,0));
        add("win_and_draw", f_chk(1,1),             o(0,1,1,0,0,1,1,2));
        add("start_after",  f_start(),              o(0,1,1,1,1,0,0,0));
        // reset with a request outstanding
        add("p1_move4",     f_p1(4),                o(1,4,0,0,0,0,0,0));
        add("rst_in_place", f_rst(),                o(0,0,0,0,0,0,0,0));
        add("idle_move",    f_p1(4),                o(0,0,0,0,0,0,0,0));
        // draw
        add("start3",       f_start(),              o(0,0,0,1,1,0,0,0));
        add("p1_move5",     f_p1(5),                o(1,5,0,0,0,0,0,0));
        add("ack_ok3",      f_ack(1),               o(0,5,0,0,0,0,0,0));
        add("draw",         f_chk(0,1),             o(0,5,0,0,0,0,1,0));
        // start ignored mid-game, checker ignored during PLACE
        add("start4",       f_start(),              o(0,5,0,1,1,0,0,0));
        add("skip_a",       f_to(),                 o(0,5,0,1,1,1,0,0));
        add("start_ignored",f_start(),              o(0,5,0,1,0,1,0,0));
        add("p2_move2",     f_p2(2),                o(1,2,1,0,0,1,0,0));
        add("chk_in_place", f_chk(1,0),             o(1,2,1,0,0,1,0,0));
        add("ack_ok4",      f_ack(1),               o(0,2,1,0,0,1,0,0));
        add("p2_wins",      f_chk(1,0),             o(0,2,1,0,0,1,1,2));
        // P1 wins
        add("start5",       f_start(),              o(0,2,1,1,1,0,0,0));
        add("p1_move0",     f_p1(0),                o(1,0,0,0,0,0,0,0));
        add("ack_ok5",      f_ack(1),               o(0,0,0,0,0,0,0,0));
        add("p1_wins",      f_chk(1,0),             o(0,0,0,0,0,0,1,1));
        // successful placement clears the skip count
        add("start6",       f_start(),              o(0,0,0,1,1,0,0,0));
        add("s_to1",        f_to(),                 o(0,0,0,1,1,1,0,0));
        add("s_to2",        f_to(),                 o(0,0,0,1,1,0,0,0));
        add("s_to3",        f_to(),                 o(0,0,0,1,1,1,0,0));
        add("s_p2_move3",   f_p2(3),                o(1,3,1,0,0,1,0,0));
        add("s_ack_ok",     f_ack(1),               o(0,3,1,0,0,1,0,0));
        add("s_chk_none",   f_chk(0,0),             o(0,3,1,1,1,0,0,0));
        add("s_to_cleared", f_to(),                 o(0,3,1,1,1,1,0,0));

        foreach (tbl[k]) begin
            run_cycle(tbl[k].i, act);
            check(tbl[k].name, 32'(act), 32'(tbl[k].o));
        end

        // Board stalls its ack: request must stay stable, timeouts ignored.
        run_cycle(f_p2(6), act);
        check("stall_req_up", 32'(act), 32'(o(1,6,1,0,0,1,0,0)));
        for (int k = 0; k < 4; k++) begin
            run_cycle((k % 2 == 0) ? f_to() : f_none(), act);
            check($sformatf("stall_hold_%0d", k), 32'(act), 32'(o(1,6,1,0,0,1,0,0)));
        end
        run_cycle(f_ack(1), act);
        check("stall_ack", 32'(act), 32'(o(0,6,1,0,0,1,0,0)));

        // Randomized run against the model.
        run_cycle(f_rst(), act);
        check("rand_reset", 32'(act), 32'(model_out()));
        for (int cyc = 0; cyc < 4000; cyc++) begin
            v = '0;
            v.rst   = ($urandom_range(0, 299) == 0);
            v.start = ($urandom_range(0, 14) == 0);
            v.p1v   = ($urandom_range(0, 3) == 0);
            v.p1c   = COL_W'($urandom_range(0, 7));
            v.p2v   = ($urandom_range(0, 3) == 0);
            v.p2c   = COL_W'($urandom_range(0, 7));
            v.to    = ($urandom_range(0, 5) == 0);
            v.ack   = (m_inflight.size() != 0) && ($urandom_range(0, 2) == 0);
            v.ok    = ($urandom_range(0, 3) != 0);
            v.cv    = ($urandom_range(0, 2) == 0);
            v.win   = ($urandom_range(0, 4) == 0);
            v.draw  = ($urandom_range(0, 5) == 0);
            run_cycle(v, act);
            exp_o = model_out();
            check($sformatf("rand_cyc_%0d", cyc), 32'(act), 32'(exp_o));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
